aging_priority_selection: RTL

- Per-input-port priority-level selector for the f-iSLIP request stage, one instance per input port.
- Each scheduling slot it picks one of P priority levels and issues a registered N-bit output request vector at that level.
- Normally the highest eligible level wins. Per-level aging counters promote a starved lower level once its wait reaches a programmable limit, so no level is locked out.
- Requests are held under a valid/grant handshake until granted or until the next slot begins.

---
 rtl/aging_priority_pkg.sv | 25 ++
 rtl/priority_msb_encoder.sv | 20 ++
 rtl/aging_priority_selection.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/aging_priority_pkg.sv
// Shared types and constants for the aging priority-level selector.
package aging_priority_pkg;

  localparam int DEF_AGE_W     = 8;
  localparam int DEF_AGE_LIMIT = 64;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        result = i + 1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_e;

endpackage

// File: rtl/priority_msb_encoder.sv
// Reports whether any bit of a vector is set and the index of the highest set bit.
module priority_msb_encoder #(
  parameter int W     = 8,
  parameter int IDX_W = 3
) (
  input  logic [W-1:0]     i_vec,
  output logic             o_any,
  output logic [IDX_W-1:0] o_idx
);

  // Later (higher) indices overwrite earlier ones, leaving the MSB position.
  always_comb begin
    o_any = |i_vec;
    o_idx = '0;
    for (int i = 0; i < W; i++) begin
      o_idx = i_vec[i] ? IDX_W'(i) : o_idx;
    end
  end

endmodule

// File: rtl/aging_priority_selection.sv
// Per-input priority-level selector: picks one level per slot, with aging promotion
// of starved levels, and holds the registered request until grant or next slot.
module aging_priority_selection
  import aging_priority_pkg::*;
#(
  parameter int N         = 24,
  parameter int P         = 8,
  parameter int AGE_W     = DEF_AGE_W,
  parameter int AGE_LIMIT = DEF_AGE_LIMIT,
  parameter int AGING_EN  = 1,
  localparam int LVL_W    = (clog2(P) > 0) ? clog2(P) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [N*P-1:0]   i_empty,
  input  logic [N*P-1:0]   i_priority,
  input  logic             i_input_idle,
  input  logic [N-1:0]     i_output_idle,
  input  logic             i_slot_start,
  input  logic             i_grant_valid,
  output logic             o_req_valid,
  output logic [P*N-1:0]   o_p_o,
  output logic [LVL_W-1:0] o_sel_level,
  output logic             o_promoted
);

  state_e             state_q, state_d;
  logic               req_valid_q, req_valid_d;
  logic [P*N-1:0]     p_o_q, p_o_d;
  logic [LVL_W-1:0]   sel_level_q, sel_level_d;
  logic               promoted_q, promoted_d;
  logic [AGE_W-1:0]   age_q [P];
  logic [AGE_W-1:0]   age_d [P];
  logic [AGE_W-1:0]   age_eval_s [P];

  logic [P-1:0]       elig_s;
  logic [P-1:0]       starved_s;
  logic               any_elig_s, any_starved_s;
  logic [LVL_W-1:0]   elig_idx_s, starved_idx_s, sel_lvl_s;
  logic [N-1:0]       req_vec_s;

  // Level eligibility and starvation from the current VOQ state and ages.
  always_comb begin
    for (int i = 0; i < P; i++) begin
      logic acc;
      acc = 1'b0;
      for (int j = 0; j < N; j++) begin
        acc = acc | (~i_empty[j*P+i] & i_output_idle[j]);
      end
      elig_s[i]    = acc;
      starved_s[i] = (AGING_EN != 0) && (age_q[i] >= AGE_W'(AGE_LIMIT));
    end
  end

  priority_msb_encoder #(.W(P), .IDX_W(LVL_W)) u_elig_enc (
    .i_vec (elig_s),
    .o_any (any_elig_s),
    .o_idx (elig_idx_s)
  );

  priority_msb_encoder #(.W(P), .IDX_W(LVL_W)) u_starved_enc (
    .i_vec (starved_s),
    .o_any (any_starved_s),
    .o_idx (starved_idx_s)
  );

  assign sel_lvl_s = any_starved_s ? starved_idx_s : elig_idx_s;

  // Request vector at the chosen level and the ages that follow a successful evaluation.
  always_comb begin
    for (int j = 0; j < N; j++) begin
      req_vec_s[j] = i_output_idle[j] & i_priority[j*P + int'(sel_lvl_s)];
    end
    for (int i = 0; i < P; i++) begin
      if (AGING_EN == 0) begin
        age_eval_s[i] = '0;
      end else if (LVL_W'(i) == sel_lvl_s) begin
        age_eval_s[i] = '0;
      end else if (elig_s[i]) begin
        age_eval_s[i] = (age_q[i] == {AGE_W{1'b1}}) ? age_q[i] : age_q[i] + AGE_W'(1);
      end else begin
        age_eval_s[i] = '0;
      end
    end
  end

  // Next-state logic: slot evaluation takes precedence over a grant.
  always_comb begin
    state_d     = state_q;
    req_valid_d = req_valid_q;
    p_o_d       = p_o_q;
    sel_level_d = sel_level_q;
    promoted_d  = promoted_q;
    age_d       = age_q;
    if (i_slot_start) begin
      if (i_input_idle && any_elig_s) begin
        p_o_d                          = '0;
        p_o_d[int'(sel_lvl_s)*N +: N]  = req_vec_s;
        req_valid_d                    = |req_vec_s;
        sel_level_d                    = sel_lvl_s;
        promoted_d                     = any_starved_s;
        state_d                        = (|req_vec_s) ? S_REQ : S_IDLE;
        age_d                          = age_eval_s;
      end else if (i_input_idle) begin
        p_o_d       = '0;
        req_valid_d = 1'b0;
        state_d     = S_IDLE;
        for (int i = 0; i < P; i++) begin
          age_d[i] = '0;
        end
      end else begin
        p_o_d       = '0;
        req_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    end else begin
      case (state_q)
        S_REQ: begin
          if (i_grant_valid) begin
            p_o_d       = '0;
            req_valid_d = 1'b0;
            state_d     = S_IDLE;
          end else begin
            state_d = S_REQ;
          end
        end
        S_IDLE: begin
          state_d = S_IDLE;
        end
        default: begin
          p_o_d       = '0;
          req_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      endcase
    end
  end

  // State, ages and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      req_valid_q <= 1'b0;
      p_o_q       <= '0;
      sel_level_q <= '0;
      promoted_q  <= 1'b0;
      for (int i = 0; i < P; i++) begin
        age_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      req_valid_q <= req_valid_d;
      p_o_q       <= p_o_d;
      sel_level_q <= sel_level_d;
      promoted_q  <= promoted_d;
      for (int i = 0; i < P; i++) begin
        age_q[i] <= age_d[i];
      end
    end
  end

  assign o_req_valid = req_valid_q;
  assign o_p_o       = p_o_q;
  assign o_sel_level = sel_level_q;
  assign o_promoted  = promoted_q;

endmodule
